// File: rtl/bit_serial_add_sub.sv
// rtl/bit_serial_add_sub.sv - bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes
// One full adder/subtractor cell, reused once per bit with a carry flop between bits.

module one_bit_full_adder_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    input  logic i_sub,
    output logic o_sum,
    output logic o_cout
);

    logic w_b_eff;

    // Subtract inverts B; the +1 of two's complement arrives as the initial carry-in.
    assign w_b_eff = i_b ^ i_sub;
    assign o_sum   = i_a ^ w_b_eff ^ i_cin;
    assign o_cout  = (i_a & w_b_eff) | (i_a & i_cin) | (w_b_eff & i_cin);

endmodule

module bit_serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_op;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;

    logic             w_sum;
    logic             w_cell_cout;
    logic             w_accept;
    logic             w_release;
    logic             w_last_bit;

    one_bit_full_adder_subtractor u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .i_sub  (r_op),
        .o_sum  (w_sum),
        .o_cout (w_cell_cout)
    );

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign w_accept   = in_valid & in_ready;
    assign w_release  = out_valid & out_ready;
    assign w_last_bit = (r_count == LAST_BIT);

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_op       <= 1'b0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= opcode;
                        r_carry <= opcode;
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at result[0] after WIDTH shifts.
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cell_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    if (w_last_bit) begin
                        r_cout     <= w_cell_cout;
                        r_overflow <= r_carry ^ w_cell_cout;
                        r_state    <= ST_DONE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_sub.sv
// tb/tb_bit_serial_add_sub.sv - directed self-checking bench for bit_serial_add_sub

module tb_bit_serial_add_sub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    bit_serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one operation and returns 1ns after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic top);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
        a        = ta;
        b        = tb_v;
        opcode   = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        opcode   = ~top;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic top, input logic [WIDTH-1:0] er, input logic ec, input logic ev);
        issue(ta, tb_v, top);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(ev));
        @(posedge clk);
        #1;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("add_100_27",  8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
        run_op("add_127_1",   8'd127, 8'd1,  1'b0, 8'h80,  1'b0, 1'b1);
        run_op("add_ff_1",    8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0);
        run_op("sub_5_3",     8'd5,   8'd3,  1'b1, 8'd2,   1'b1, 1'b0);
        run_op("sub_3_5",     8'd3,   8'd5,  1'b1, 8'hFE,  1'b0, 1'b0);
        run_op("sub_80_1",    8'h80,  8'h01, 1'b1, 8'h7F,  1'b1, 1'b1);

        // Backpressure with in_valid pulses during RUN and DONE
        out_ready = 1'b0;
        issue(8'h40, 8'h40, 1'b0);
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (i <= WIDTH - 2) begin
                in_valid = 1'b1;
                a        = 8'h11;
                b        = 8'h22;
                check("bp_run_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'h33;
            b        = 8'h44;
            check("bp_done_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'h80);
            check("bp_hold_cout", 32'(cout), 32'd0);
            check("bp_hold_ovf", 32'(overflow), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);

        // Reset arriving on the edge that would process bit 3
        issue(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        run_op("sub_10_20", 8'd10, 8'd20, 1'b1, 8'hF6, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
